sram_bist_seq: RTL and testbench

SRAM_BIST_SEQ -- requirements
Module: sram_bist_seq

---
 rtl/sram_seq_pkg.sv | 20 ++
 rtl/seq_wait_timer.sv | 29 ++
 rtl/sram_bist_seq.sv | 137 +++++++++++++
 tb/tb_sram_bist_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
// rtl/sram_seq_pkg.sv - shared state encoding and default parameters for the SRAM BIST sequencer
package sram_seq_pkg;

   localparam int         DEF_ADDR_W        = 17;
   localparam int         DEF_DATA_W        = 8;
   localparam int         DEF_LAST_ADDR     = 255;
   localparam int         DEF_ACCESS_CYCLES = 4;
   localparam logic [7:0] DEF_SEED          = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      WR_ISSUE,
      WR_WAIT,
      RD_ISSUE,
      RD_WAIT,
      CHECK,
      FINISH
   } seq_state_t;

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - access latency countdown; expired is high on the last wait cycle
module seq_wait_timer #(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic tick,
   output logic expired
);

   localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CNT_W-1:0] cnt;

   // Loaded with CYCLES-1 so that the wait state lasts exactly CYCLES cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(CYCLES - 1);
      end else if (tick && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/sram_bist_seq.sv
// rtl/sram_bist_seq.sv - SRAM write/read-back BIST sequencer; SEQ_INVERT_PASS_EN adds an inverted second pass
module sram_bist_seq
   import sram_seq_pkg::*;
#(
   parameter int                ADDR_W        = DEF_ADDR_W,
   parameter int                DATA_W        = DEF_DATA_W,
   parameter int                LAST_ADDR     = DEF_LAST_ADDR,
   parameter int                ACCESS_CYCLES = DEF_ACCESS_CYCLES,
   parameter logic [DATA_W-1:0] SEED          = DEF_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              wr_request,
   output logic              rd_request,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_cnt,
   output logic [ADDR_W-1:0] fail_addr
);

   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);

`ifdef SEQ_INVERT_PASS_EN
   localparam logic TWO_PASS = 1'b1;
`else
   localparam logic TWO_PASS = 1'b0;
`endif

   seq_state_t        state, state_nxt;
   logic              inv_q;
   logic              timer_load, timer_tick, timer_expired;
   logic              addr_inc, addr_clr, inv_set;
   logic              last_addr, mismatch;
   logic [DATA_W-1:0] pattern;

   assign last_addr = (addr == LAST_A);
   assign pattern   = inv_q ? ~(addr[DATA_W-1:0] ^ SEED) : (addr[DATA_W-1:0] ^ SEED);
   assign mismatch  = (state == CHECK) && (rd_data != pattern);

   seq_wait_timer #(.CYCLES(ACCESS_CYCLES)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .tick    (timer_tick),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      timer_load = 1'b0;
      timer_tick = 1'b0;
      addr_inc   = 1'b0;
      addr_clr   = 1'b0;
      inv_set    = 1'b0;
      case (state)
         IDLE:     if (start) state_nxt = WR_ISSUE;
         WR_ISSUE: begin
            state_nxt  = WR_WAIT;
            timer_load = 1'b1;
         end
         WR_WAIT: begin
            timer_tick = 1'b1;
            if (timer_expired) begin
               state_nxt = last_addr ? RD_ISSUE : WR_ISSUE;
               addr_clr  = last_addr;
               addr_inc  = !last_addr;
            end
         end
         RD_ISSUE: begin
            state_nxt  = RD_WAIT;
            timer_load = 1'b1;
         end
         RD_WAIT: begin
            timer_tick = 1'b1;
            if (timer_expired) state_nxt = CHECK;
         end
         CHECK: begin
            if (!last_addr) begin
               state_nxt = RD_ISSUE;
               addr_inc  = 1'b1;
            end else if (TWO_PASS && !inv_q) begin
               state_nxt = WR_ISSUE;
               addr_clr  = 1'b1;
               inv_set   = 1'b1;
            end else begin
               state_nxt = FINISH;
            end
         end
         FINISH:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // err_cnt never returns to zero once incremented, so zero marks "no mismatch yet"
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr      <= '0;
         inv_q     <= 1'b0;
         err_cnt   <= '0;
         fail_addr <= '0;
         pass      <= 1'b0;
      end else if ((state == IDLE) && start) begin
         addr      <= '0;
         inv_q     <= 1'b0;
         err_cnt   <= '0;
         fail_addr <= '0;
         pass      <= 1'b0;
      end else begin
         if (addr_clr)      addr <= '0;
         else if (addr_inc) addr <= addr + ADDR_W'(1);
         if (inv_set) inv_q <= 1'b1;
         if (mismatch) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (err_cnt == 8'd0)  fail_addr <= addr;
         end
         if ((state == CHECK) && (state_nxt == FINISH))
            pass <= (err_cnt == 8'd0) && !mismatch;
      end
   end

   assign wr_request = (state == WR_ISSUE);
   assign rd_request = (state == RD_ISSUE);
   assign busy       = (state != IDLE) && (state != FINISH);
   assign done       = (state == FINISH);
   assign wr_data    = ((state == WR_ISSUE) || (state == WR_WAIT)) ? pattern : '0;

endmodule

// File: tb/tb_sram_bist_seq.sv
// tb/tb_sram_bist_seq.sv - randomized self-checking bench for sram_bist_seq against an SRAM fault model
module tb_sram_bist_seq;

   localparam int ADDR_W        = 9;
   localparam int DATA_W        = 8;
   localparam int LAST_ADDR     = 511;
   localparam int ACCESS_CYCLES = 2;
   localparam int N_ADDR        = LAST_ADDR + 1;
`ifdef SEQ_INVERT_PASS_EN
   localparam int N_PASS = 2;
`else
   localparam int N_PASS = 1;
`endif
   localparam int RUN_CYCLES = N_PASS * N_ADDR * (2 * (ACCESS_CYCLES + 1) + 1) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              wr_request, rd_request;
   logic [ADDR_W-1:0] addr, fail_addr;
   logic [DATA_W-1:0] wr_data, rd_data;
   logic              busy, done, pass;
   logic [7:0]        err_cnt;

   int checks   = 0;
   int failures = 0;

   // SRAM model: 0 ideal, 1 one stuck address, 2 always FF, 3 per-address bit flips
   logic [7:0] mem  [N_ADDR];
   logic [7:0] flip [N_ADDR];
   int         mode;
   int         stuck_addr;
   logic [7:0] stuck_val;

   int wr_idx, wr_bad, rd_cnt, overlap_cnt;

   always #5 clk = ~clk;

   sram_bist_seq #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .LAST_ADDR     (LAST_ADDR),
      .ACCESS_CYCLES (ACCESS_CYCLES),
      .SEED          (8'hA5)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .wr_request (wr_request),
      .rd_request (rd_request),
      .addr       (addr),
      .wr_data    (wr_data),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_cnt    (err_cnt),
      .fail_addr  (fail_addr)
   );

   function automatic logic [7:0] pat(input int a, input int p);
      logic [7:0] v;
      v = 8'(a) ^ 8'hA5;
      return (p != 0) ? ~v : v;
   endfunction

   always_comb begin
      if (mode == 2)                               rd_data = 8'hFF;
      else if (mode == 1 && int'(addr) == stuck_addr) rd_data = stuck_val;
      else                                         rd_data = mem[addr] ^ flip[addr];
   end

   always @(posedge clk) begin
      if (wr_request) begin
         if (int'(addr) != (wr_idx % N_ADDR) || wr_data != pat(wr_idx % N_ADDR, wr_idx / N_ADDR))
            wr_bad++;
         mem[addr] <= wr_data;
         wr_idx++;
      end
      if (rd_request) rd_cnt++;
      if (wr_request && rd_request) overlap_cnt++;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_result(output int errs, output int faddr, output bit ok);
      int total;
      logic [7:0] got;
      total = 0;
      faddr = 0;
      for (int p = 0; p < N_PASS; p++) begin
         for (int a = 0; a < N_ADDR; a++) begin
            if (mode == 2)                        got = 8'hFF;
            else if (mode == 1 && a == stuck_addr) got = stuck_val;
            else                                  got = pat(a, p) ^ flip[a];
            if (got != pat(a, p)) begin
               if (total == 0) faddr = a;
               total++;
            end
         end
      end
      errs = (total > 255) ? 255 : total;
      ok   = (total == 0);
   endtask

   task automatic set_mode(input int m);
      mode = m;
      for (int a = 0; a < N_ADDR; a++) flip[a] = 8'h00;
      if (m == 3) begin
         for (int k = 0; k < 6; k++)
            flip[$urandom_range(N_ADDR - 1)] = 8'($urandom_range(255, 1));
      end
   endtask

   task automatic run_test(input string tag, input int repulse_at);
      int n;
      int exp_err, exp_fa;
      bit exp_pass, got_done;
      expect_result(exp_err, exp_fa, exp_pass);
      @(negedge clk);
      wr_idx = 0; wr_bad = 0; rd_cnt = 0; overlap_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1);
      n = 1;
      got_done = 0;
      while (n <= RUN_CYCLES + 20) begin
         if (done) begin
            got_done = 1;
            break;
         end
         start = (n == repulse_at);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, got_done, 1);
      check({tag, "_cycles"}, n, RUN_CYCLES);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_pass"}, pass, exp_pass);
      check({tag, "_err_cnt"}, err_cnt, exp_err);
      check({tag, "_fail_addr"}, fail_addr, exp_fa);
      check({tag, "_writes"}, wr_idx, N_PASS * N_ADDR);
      check({tag, "_write_pattern"}, wr_bad, 0);
      check({tag, "_reads"}, rd_cnt, N_PASS * N_ADDR);
      check({tag, "_no_overlap"}, overlap_cnt, 0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_pass_held"}, pass, exp_pass);
   endtask

   task automatic reset_mid_run();
      int n, done_seen;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!rd_request && n < RUN_CYCLES) begin
         @(negedge clk);
         n++;
      end
      check("rst_reached_read", rd_request, 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_outputs_zero",
            {wr_request, rd_request, addr, wr_data, busy, done, pass, err_cnt, fail_addr}, 0);
      @(negedge clk);
      rst = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("rst_no_done_no_busy", done_seen, 0);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      stuck_addr = 0;
      stuck_val = 8'h00;
      set_mode(0);
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {wr_request, rd_request, addr, wr_data, busy, done, pass, err_cnt, fail_addr}, 0);
      rst = 1'b1;

      run_test("ideal", -1);

      set_mode(1);
      stuck_addr = 2;
      stuck_val = 8'h00;
      run_test("stuck2", -1);

      set_mode(2);
      run_test("all_ff", -1);

      set_mode(3);
      run_test("flips_repulse", $urandom_range(RUN_CYCLES - 3, 2));

      set_mode(0);
      reset_mid_run();
      run_test("after_reset", -1);

      for (int it = 0; it < 2; it++) begin
         set_mode($urandom_range(3, 1));
         stuck_addr = $urandom_range(LAST_ADDR);
         stuck_val = 8'($urandom_range(255));
         run_test($sformatf("rand%0d", it), $urandom_range(RUN_CYCLES - 3, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
